// File: rtl/sync_fifo_flex.sv
// sync_fifo_flex: single-clock FIFO with occupancy count, almost flags, flush and sticky error flags.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads; otherwise rdata is registered.
module sync_fifo_flex #(
  parameter int WIDTH     = 8,
  parameter int ADDR      = 4,
  parameter int AFULL_TH  = (1 << ADDR) - 2,
  parameter int AEMPTY_TH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             wen,
  input  logic [WIDTH-1:0] wdata,
  input  logic             ren,
  input  logic             err_clr,
  output logic [WIDTH-1:0] rdata,
  output logic             rvalid,
  output logic             empty,
  output logic             full,
  output logic             almost_empty,
  output logic             almost_full,
  output logic [ADDR:0]    count,
  output logic             overflow,
  output logic             underflow
);
  localparam int DEPTH = 1 << ADDR;
  localparam logic [ADDR:0] DEPTH_C = {1'b1, {ADDR{1'b0}}};
  localparam logic [ADDR:0] AF_C = AFULL_TH[ADDR:0];
  localparam logic [ADDR:0] AE_C = AEMPTY_TH[ADDR:0];
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic             ovf_q, ovf_d, unf_q, unf_d;
  logic             wr_acc, rd_acc;
  // Pointers carry a wrap bit so full and empty differ even when the indices match.
  assign count        = wptr_q - rptr_q;
  assign empty        = count == '0;
  assign full         = count == DEPTH_C;
  assign almost_empty = count <= AE_C;
  assign almost_full  = count >= AF_C;
  assign wr_acc       = wen && !full && !flush;
  assign rd_acc       = ren && !empty && !flush;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;
  always_comb begin
    wptr_d = flush ? '0 : wptr_q + {{ADDR{1'b0}}, wr_acc};
    rptr_d = flush ? '0 : rptr_q + {{ADDR{1'b0}}, rd_acc};
    ovf_d  = (wen && full && !flush) || (ovf_q && !err_clr);
    unf_d  = (ren && empty && !flush) || (unf_q && !err_clr);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      ovf_q  <= ovf_d;
      unf_q  <= unf_d;
    end
  end
  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wptr_q[ADDR-1:0]] <= wdata;
  end
`ifdef SYNC_FIFO_FWFT_EN
  assign rdata  = mem_q[rptr_q[ADDR-1:0]];
  assign rvalid = !empty;
`else
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             rvalid_q;
  assign rdata_d = rd_acc ? mem_q[rptr_q[ADDR-1:0]] : rdata_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rdata_q  <= rdata_d;
      rvalid_q <= rd_acc;
    end
  end
  assign rdata  = rdata_q;
  assign rvalid = rvalid_q;
`endif
endmodule

// File: tb/tb_sync_fifo_flex.sv
// tb_sync_fifo_flex: directed scoreboard bench for sync_fifo_flex (WIDTH=8, ADDR=4, AFULL_TH=14, AEMPTY_TH=2).
module tb_sync_fifo_flex;
  logic       clk = 1'b0;
  logic       rst_n, flush, wen, ren, err_clr;
  logic [7:0] wdata, rdata;
  logic       rvalid, empty, full, almost_empty, almost_full, overflow, underflow;
  logic [4:0] count;
  int         errors = 0;
  int         checks = 0;
  logic [7:0] exp_q[$];

  sync_fifo_flex #(.WIDTH(8), .ADDR(4), .AFULL_TH(14), .AEMPTY_TH(2)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .wen(wen), .wdata(wdata), .ren(ren),
    .err_clr(err_clr), .rdata(rdata), .rvalid(rvalid), .empty(empty), .full(full),
    .almost_empty(almost_empty), .almost_full(almost_full), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic w, input logic [7:0] wd, input logic r,
                       input logic f = 1'b0, input logic ec = 1'b0);
    wen = w; wdata = wd; ren = r; flush = f; err_clr = ec;
    @(posedge clk); #1;
    wen = 1'b0; ren = 1'b0; flush = 1'b0; err_clr = 1'b0;
  endtask

  // Scoreboard monitor: every presented output word must match the oldest expected word.
  always @(negedge clk) begin
    logic [7:0] e;
`ifdef SYNC_FIFO_FWFT_EN
    if (rst_n && ren && rvalid && !flush) begin
`else
    if (rst_n && rvalid) begin
`endif
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rdata_unexpected got=%0h want=none", rdata);
      end else begin
        e = exp_q.pop_front();
        if (rdata !== e) begin
          errors++;
          $display("FAIL rdata got=%0h want=%0h", rdata, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int wn, rn, it;
    logic [7:0] wd;
    rst_n = 1'b0; flush = 1'b0; wen = 1'b0; ren = 1'b0; err_clr = 1'b0; wdata = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    // 1. reset state
    chk("rst_empty", 32'(empty), 1);
    chk("rst_aempty", 32'(almost_empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_afull", 32'(almost_full), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_rvalid", 32'(rvalid), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_unf", 32'(underflow), 0);
`ifndef SYNC_FIFO_FWFT_EN
    chk("rst_rdata", 32'(rdata), 0);
`endif
    // 2. fill to full, then overflow
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 8'(i), 1'b0);
      chk("fill_count", 32'(count), 32'(i + 1));
      chk("fill_aempty", 32'(almost_empty), 32'(i + 1 <= 2));
      chk("fill_afull", 32'(almost_full), 32'(i + 1 >= 14));
      chk("fill_full", 32'(full), 32'(i == 15));
    end
    drive(1'b1, 8'hAA, 1'b0);
    chk("ovf_count", 32'(count), 16);
    chk("ovf_flag", 32'(overflow), 1);
    // 3. drain, underflow, error clear
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back(8'(i));
      drive(1'b0, 8'h00, 1'b1);
      chk("drain_empty", 32'(empty), 32'(i == 15));
    end
    drive(1'b0, 8'h00, 1'b1);
    chk("unf_flag", 32'(underflow), 1);
`ifndef SYNC_FIFO_FWFT_EN
    chk("unf_rdata_hold", 32'(rdata), 32'h0F);
    chk("unf_rvalid", 32'(rvalid), 0);
`endif
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("clr_ovf", 32'(overflow), 0);
    chk("clr_unf", 32'(underflow), 0);
    // 4. simultaneous read/write at count=5 and at full
    for (int i = 0; i < 5; i++) drive(1'b1, 8'(8'h20 + i), 1'b0);
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(8'(8'h20 + i));
      drive(1'b1, 8'(8'h25 + i), 1'b1);
      chk("rw_count", 32'(count), 5);
    end
    for (int i = 0; i < 11; i++) drive(1'b1, 8'(8'h29 + i), 1'b0);
    chk("rw_full", 32'(full), 1);
    exp_q.push_back(8'h24);
    drive(1'b1, 8'hBB, 1'b1);
    chk("rwfull_count", 32'(count), 15);
    chk("rwfull_ovf", 32'(overflow), 1);
    for (int i = 0; i < 15; i++) begin
      exp_q.push_back(8'(8'h25 + i));
      drive(1'b0, 8'h00, 1'b1);
    end
    chk("rw_empty", 32'(empty), 1);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("rw_clr_ovf", 32'(overflow), 0);
    // 5. wrap with random gaps, every write and read accepted
    wn = 0; rn = 0; it = 0; wd = 8'h00;
    while (rn < 40 && it < 2000) begin
      logic w, r;
      w = (wn < 40) && (wn - rn < 16) && ($urandom_range(0, 2) != 0);
      r = (rn < wn) && ($urandom_range(0, 2) == 0);
      if (r) begin
        exp_q.push_back(8'h40 + rn[7:0]);
        rn++;
      end
      if (w) begin
        wd = 8'h40 + wn[7:0];
        wn++;
      end
      drive(w, wd, r);
      chk("wrap_count", 32'(count), 32'(wn - rn));
      it++;
    end
    chk("wrap_done", 32'(rn), 40);
    // 6. flush at count=9 drops the concurrent write and leaves flags alone
    for (int i = 0; i < 9; i++) drive(1'b1, 8'(8'h60 + i), 1'b0);
    chk("pre_flush_count", 32'(count), 9);
    drive(1'b1, 8'hEE, 1'b0, 1'b1);
    chk("flush_count", 32'(count), 0);
    chk("flush_empty", 32'(empty), 1);
    chk("flush_ovf", 32'(overflow), 0);
    drive(1'b1, 8'h71, 1'b0);
    exp_q.push_back(8'h71);
    drive(1'b0, 8'h00, 1'b1);
`ifdef SYNC_FIFO_FWFT_EN
    drive(1'b1, 8'h5A, 1'b0);
    chk("fwft_empty", 32'(empty), 0);
    chk("fwft_rdata", 32'(rdata), 32'h5A);
    chk("fwft_rvalid", 32'(rvalid), 1);
    exp_q.push_back(8'h5A);
    drive(1'b0, 8'h00, 1'b1);
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
